letc_core_stage_f2: RTL

- Second fetch stage of the LETC core; sits between F1 and decode.
- Takes the translated fetch address from F1 and issues one request to the L1 instruction cache.
- Waits for the response and registers the instruction word, PC, and fault flag to decode.
- Handles stall, flush, and draining of responses orphaned by a flush.

---
 rtl/letc_core_stage_f2.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/letc_core_stage_f2.sv
// LETC core F2: issues one L1I request per F1 word and registers the response to decode.
// Optional LETC_CORE_F2_PERF_EN adds the saturating o_wait_cycles memory-wait counter.
package letc_core_stage_f2_pkg;
  typedef logic [31:0] word_t;
  typedef logic [31:0] paddr_t;
  typedef logic [29:0] pc_word_t;

  typedef struct packed {
    logic     valid;
    pc_word_t pc_word;
    paddr_t   fetch_addr;
  } f1_to_f2_s;

  typedef struct packed {
    logic     valid;
    pc_word_t pc_word;
    word_t    instr;
    logic     fault;
  } f2_to_d_s;
endpackage

module letc_core_stage_f2
  import letc_core_stage_f2_pkg::*;
#(
  parameter int STALL_CNTR_W = 16
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  f1_to_f2_s i_f1_to_f2,
  output logic      o_icache_req_valid,
  input  logic      i_icache_req_ready,
  output paddr_t    o_icache_req_addr,
  input  logic      i_icache_rsp_valid,
  input  word_t     i_icache_rsp_data,
  input  logic      i_icache_rsp_fault,
  output logic      o_stage_ready,
  input  logic      i_stage_flush,
  input  logic      i_stage_stall,
  output f2_to_d_s  o_f2_to_d
`ifdef LETC_CORE_F2_PERF_EN
  ,
  output logic [STALL_CNTR_W-1:0] o_wait_cycles
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    HOLD     = 2'd2,
    DISCARD  = 2'd3
  } state_e;

  if (STALL_CNTR_W < 2) begin : g_bad_cntr_w
    $error("STALL_CNTR_W must be at least 2");
  end

  state_e   state_q;
  logic     out_valid_q;
  pc_word_t out_pc_q;
  word_t    out_instr_q;
  logic     out_fault_q;
  pc_word_t req_pc_q;
  pc_word_t hold_pc_q;
  word_t    hold_instr_q;
  logic     hold_fault_q;

  logic in_idle;
  logic req_fire;
  logic load_rsp;
  logic load_hold;
  logic capture_hold;

  always_comb begin
    in_idle            = (state_q == IDLE);
    o_icache_req_valid = in_idle & i_f1_to_f2.valid & ~i_stage_flush;
    o_icache_req_addr  = i_f1_to_f2.fetch_addr;
    o_stage_ready      = in_idle & (~i_f1_to_f2.valid | i_icache_req_ready) & ~i_stage_flush;
    req_fire           = o_icache_req_valid & i_icache_req_ready;
    load_rsp     = (state_q == WAIT_RSP) & i_icache_rsp_valid & ~i_stage_stall & ~i_stage_flush;
    capture_hold = (state_q == WAIT_RSP) & i_icache_rsp_valid &  i_stage_stall & ~i_stage_flush;
    load_hold    = (state_q == HOLD) & ~i_stage_stall & ~i_stage_flush;
  end

  // Flush beats stall for the output valid; an orphaned request parks in DISCARD.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      if (i_stage_flush) begin
        out_valid_q <= 1'b0;
      end else if (!i_stage_stall) begin
        out_valid_q <= load_rsp | load_hold;
      end

      case (state_q)
        IDLE: begin
          if (req_fire) state_q <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (i_stage_flush) begin
            state_q <= i_icache_rsp_valid ? IDLE : DISCARD;
          end else if (i_icache_rsp_valid) begin
            state_q <= i_stage_stall ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (i_stage_flush || !i_stage_stall) state_q <= IDLE;
        end
        DISCARD: begin
          if (i_icache_rsp_valid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (req_fire) begin
      req_pc_q <= i_f1_to_f2.pc_word;
    end
    if (capture_hold) begin
      hold_pc_q    <= req_pc_q;
      hold_instr_q <= i_icache_rsp_data;
      hold_fault_q <= i_icache_rsp_fault;
    end
    if (load_rsp) begin
      out_pc_q    <= req_pc_q;
      out_instr_q <= i_icache_rsp_data;
      out_fault_q <= i_icache_rsp_fault;
    end else if (load_hold) begin
      out_pc_q    <= hold_pc_q;
      out_instr_q <= hold_instr_q;
      out_fault_q <= hold_fault_q;
    end
  end

  assign o_f2_to_d = '{valid: out_valid_q, pc_word: out_pc_q, instr: out_instr_q, fault: out_fault_q};

`ifdef LETC_CORE_F2_PERF_EN
  logic [STALL_CNTR_W-1:0] wait_cycles_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wait_cycles_q <= '0;
    end else if (((state_q == WAIT_RSP) || (state_q == DISCARD)) && (wait_cycles_q != '1)) begin
      wait_cycles_q <= wait_cycles_q + {{(STALL_CNTR_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_wait_cycles = wait_cycles_q;
`endif

`ifndef SYNTHESIS
  // A response is only legal while a request is outstanding.
  a_rsp_only_when_outstanding: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_icache_rsp_valid |-> ((state_q == WAIT_RSP) || (state_q == DISCARD)));
`endif

endmodule
